mctrl_axi_gate: RTL



---
 rtl/mctrl_axi_gate.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mctrl_axi_gate.sv
// AXI gate between the SoC memory master and the DDR controller slave.
// Holds the SoC in reset until calibration has been stable, tracks
// outstanding transactions, and drains them when calibration is lost.

package mctrl_axi_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

module mctrl_axi_gate #(
    parameter int unsigned StartupCycles  = 16,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned DrainTimeout   = 1024,
    parameter type axi_req_t = mctrl_axi_pkg::axi_req_t,
    parameter type axi_rsp_t = mctrl_axi_pkg::axi_rsp_t,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            calib_i,
    output logic            soc_rst_no,
    input  axi_req_t        slv_req_i,
    output axi_rsp_t        slv_rsp_o,
    output axi_req_t        mst_req_o,
    input  axi_rsp_t        mst_rsp_i,
    output logic [1:0]      state_o,
    output logic [CntW-1:0] wr_outstanding_o,
    output logic [CntW-1:0] rd_outstanding_o,
    output logic            drain_timeout_o
);

    localparam int unsigned SuW = (StartupCycles > 1) ? $clog2(StartupCycles) : 1;
    localparam int unsigned DrW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        STARTUP    = 2'd1,
        RUN        = 2'd2,
        DRAIN      = 2'd3
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            w_timeout;
    logic            r_soc_rst_n;
    logic            r_timeout;
    logic [SuW-1:0]  r_startup_cnt;
    logic [DrW-1:0]  r_drain_cnt;
    logic [CntW-1:0] r_wr_cnt;
    logic [CntW-1:0] r_rd_cnt;
    logic [CntW-1:0] w_wr_next;
    logic [CntW-1:0] w_rd_next;
    logic            w_aw_ok;
    logic            w_ar_ok;
    logic            w_data_ok;
    logic            w_aw_hs;
    logic            w_b_hs;
    logic            w_ar_hs;
    logic            w_r_last_hs;

    // Channel enables: AW/AR only in RUN below the limit, W/B/R in RUN and DRAIN
    always_comb begin
        w_aw_ok   = (r_state == RUN) && (r_wr_cnt != CntW'(MaxOutstanding));
        w_ar_ok   = (r_state == RUN) && (r_rd_cnt != CntW'(MaxOutstanding));
        w_data_ok = (r_state == RUN) || (r_state == DRAIN);
    end

    // Pass payloads through and gate every valid/ready with the channel enables
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & w_aw_ok;
        mst_req_o.ar_valid = slv_req_i.ar_valid & w_ar_ok;
        mst_req_o.w_valid  = slv_req_i.w_valid  & w_data_ok;
        mst_req_o.b_ready  = slv_req_i.b_ready  & w_data_ok;
        mst_req_o.r_ready  = slv_req_i.r_ready  & w_data_ok;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & w_aw_ok;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & w_ar_ok;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready  & w_data_ok;
        slv_rsp_o.b_valid  = mst_rsp_i.b_valid  & w_data_ok;
        slv_rsp_o.r_valid  = mst_rsp_i.r_valid  & w_data_ok;
    end

    // Handshakes and next outstanding counts; a decrement at zero holds zero
    always_comb begin
        w_aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
        w_ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
        w_b_hs      = slv_rsp_o.b_valid & slv_req_i.b_ready;
        w_r_last_hs = slv_rsp_o.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
        w_wr_next   = r_wr_cnt;
        w_rd_next   = r_rd_cnt;
        if (w_aw_hs && !w_b_hs) begin
            w_wr_next = r_wr_cnt + CntW'(1);
        end else if (!w_aw_hs && w_b_hs && (r_wr_cnt != '0)) begin
            w_wr_next = r_wr_cnt - CntW'(1);
        end
        if (w_ar_hs && !w_r_last_hs) begin
            w_rd_next = r_rd_cnt + CntW'(1);
        end else if (!w_ar_hs && w_r_last_hs && (r_rd_cnt != '0)) begin
            w_rd_next = r_rd_cnt - CntW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            WAIT_CALIB: if (calib_i) w_state_next = STARTUP;
            STARTUP: begin
                if (!calib_i) begin
                    w_state_next = WAIT_CALIB;
                end else if (r_startup_cnt == '0) begin
                    w_state_next = RUN;
                end
            end
            RUN: if (!calib_i) w_state_next = DRAIN;
            DRAIN: begin
                if ((r_wr_cnt == '0) && (r_rd_cnt == '0)) begin
                    w_state_next = WAIT_CALIB;
                end else if (r_drain_cnt == '0) begin
                    w_state_next = WAIT_CALIB;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = WAIT_CALIB;
        endcase
    end

    // State register, registered SoC reset and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= WAIT_CALIB;
            r_soc_rst_n <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_soc_rst_n <= (w_state_next == RUN) || (w_state_next == DRAIN);
            if (w_timeout) r_timeout <= 1'b1;
        end
    end

    // Startup and drain down-counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_startup_cnt <= '0;
            r_drain_cnt   <= '0;
        end else begin
            if ((r_state == WAIT_CALIB) && calib_i) begin
                r_startup_cnt <= SuW'(StartupCycles - 1);
            end else if ((r_state == STARTUP) && calib_i && (r_startup_cnt != '0)) begin
                r_startup_cnt <= r_startup_cnt - SuW'(1);
            end
            if ((r_state == RUN) && !calib_i) begin
                r_drain_cnt <= DrW'(DrainTimeout - 1);
            end else if ((r_state == DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - SuW'(0) - DrW'(1);
            end
        end
    end

    // Outstanding counters; cleared whenever DRAIN hands back to WAIT_CALIB
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if ((r_state == DRAIN) && (w_state_next == WAIT_CALIB)) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_wr_cnt <= w_wr_next;
            r_rd_cnt <= w_rd_next;
        end
    end

    assign soc_rst_no       = r_soc_rst_n;
    assign state_o          = r_state;
    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;
    assign drain_timeout_o  = r_timeout;

endmodule
